// File: rtl/ltst_32_pkg.sv
// ltst_32 shared types and constants.
// Build option: LTST_32_UNSIGNED_EN adds the is_unsigned operand qualifier.
package ltst_32_pkg;

  localparam int WIDTH = 32;

  localparam logic [31:0] SLT_TRUE  = 32'd1;
  localparam logic [31:0] SLT_FALSE = 32'd0;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             uns;
  } ltst_op_t;

  function automatic logic [31:0] slt_word(input logic lt);
    return lt ? SLT_TRUE : SLT_FALSE;
  endfunction

endpackage

// File: rtl/ltst_32_cmp.sv
// ltst_32 combinational less-than.
// Build option: LTST_32_UNSIGNED_EN (uns is tied low when absent).
module ltst_32_cmp
  import ltst_32_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         uns,
  output logic         lt
);

  logic         a_ext;
  logic         b_ext;
  logic [W:0]   diff;

  // Extend by one bit (sign or zero) so the borrow is the answer.
  always_comb begin
    a_ext = uns ? 1'b0 : a[W-1];
    b_ext = uns ? 1'b0 : b[W-1];
    diff  = {a_ext, a} - {b_ext, b};
    lt    = diff[W];
  end

endmodule

// File: rtl/ltst_32.sv
// ltst_32 registered set-less-than, one cycle latency.
// Build option: LTST_32_UNSIGNED_EN adds is_unsigned (unsigned compare).
module ltst_32
  import ltst_32_pkg::*;
#(
  parameter int WIDTH = ltst_32_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
`ifdef LTST_32_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] C,
  output logic             out_valid
);

  ltst_op_t op;
  logic     lt;
  logic     c_q;
  logic     v_q;

  // Bundle the operands presented this cycle.
  always_comb begin
    op.a   = A;
    op.b   = B;
`ifdef LTST_32_UNSIGNED_EN
    op.uns = is_unsigned;
`else
    op.uns = 1'b0;
`endif
  end

  ltst_32_cmp #(
    .W (WIDTH)
  ) u_cmp (
    .a   (op.a),
    .b   (op.b),
    .uns (op.uns),
    .lt  (lt)
  );

  // Capture on valid, hold otherwise; reset wins over valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        c_q <= lt;
      end
    end
  end

  assign C         = slt_word(c_q);
  assign out_valid = v_q;

endmodule

// File: tb/tb_ltst_32.sv
// ltst_32 directed bench.
// Optional LTST_32_UNSIGNED_EN steps follow the same build macro.
module tb_ltst_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        in_valid;
`ifdef LTST_32_UNSIGNED_EN
  logic        is_unsigned;
`endif
  logic [31:0] C;
  logic        out_valid;

  int total;
  int passed;

  ltst_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (A),
    .B           (B),
    .in_valid    (in_valid),
`ifdef LTST_32_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .C           (C),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic v, input logic r);
    A        = a;
    B        = b;
    in_valid = v;
    rst_n    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string tag, input logic [31:0] ec,
                      input logic ev);
    chk({tag, "_c"}, C, ec);
    chk({tag, "_v"}, {31'd0, out_valid}, {31'd0, ev});
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    rst_n    = 1'b0;
    A        = '0;
    B        = '0;
    in_valid = 1'b0;
`ifdef LTST_32_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    #1;
    step(32'd1, 32'd2, 1'b1, 1'b0);
    chk2("rst_prio", 32'd0, 1'b0);
    step(32'd1, 32'd2, 1'b1, 1'b0);
    chk2("rst_hold", 32'd0, 1'b0);

    step(32'd1568264235, 32'd10, 1'b1, 1'b1);
    chk2("first", 32'd0, 1'b1);
    step(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
    chk2("neg1_lt_0", 32'd1, 1'b1);
    step(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
    chk2("equal", 32'd0, 1'b1);
    step(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
    chk2("min_max", 32'd1, 1'b1);
    step(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    chk2("max_min", 32'd0, 1'b1);

    step(32'd3, 32'd5, 1'b1, 1'b1);
    chk2("b2b_0", 32'd1, 1'b1);
    step(32'd5, 32'd3, 1'b1, 1'b1);
    chk2("b2b_1", 32'd0, 1'b1);
    step(-32'sd7, -32'sd2, 1'b1, 1'b1);
    chk2("b2b_2", 32'd1, 1'b1);

    step(32'd5, 32'd0, 1'b0, 1'b1);
    chk2("idle_hold", 32'd1, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b1);
    chk2("idle_hold2", 32'd1, 1'b0);

    step(32'd7, 32'd7, 1'b1, 1'b1);
    chk2("eq_small", 32'd0, 1'b1);
    step(32'd1, 32'd2, 1'b1, 1'b1);
    chk2("pre_glitch", 32'd1, 1'b1);
    A        = 32'd9;
    B        = 32'd0;
    in_valid = 1'b0;
    #3;
    chk2("mid_cycle", 32'd1, 1'b1);
    @(posedge clk);
    #1;
    chk2("post_glitch", 32'd1, 1'b0);

    step(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    chk2("min_lt_1", 32'd1, 1'b1);
    step(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    chk2("mid_rst", 32'd0, 1'b0);
    step(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    chk2("after_rst", 32'd1, 1'b1);

`ifdef LTST_32_UNSIGNED_EN
    is_unsigned = 1'b1;
    step(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
    chk2("u_big", 32'd0, 1'b1);
    step(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    chk2("u_mid", 32'd1, 1'b1);
    is_unsigned = 1'b0;
    step(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    chk2("s_mid", 32'd0, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ltst_32.md
LTST_32 -- requirements
Module: ltst_32

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 A  input  WIDTH  first operand, two's-complement.
REQ-005 B  input  WIDTH  second operand, two's-complement.
REQ-006 in_valid  input  1  A/B (and is_unsigned when present) are sampled this cycle.
REQ-007 is_unsigned  input  1  present only with LTST_32_UNSIGNED_EN; 1 = unsigned compare.
REQ-008 C  output  WIDTH  set-less-than result: 32'd1 if A < B, else 32'd0.
REQ-009 out_valid  output  1  C holds the result of a sampled operation.

Function
REQ-010 Default compare SHALL be signed: result bit = (A <s B), computed via the WIDTH+1-bit difference A - B, or via sign-aware compare, with no overflow error.
REQ-011 C[WIDTH-1:1] SHALL always be zero; only C[0] carries the result.
REQ-012 Latency SHALL be exactly one cycle: operands sampled with in_valid=1 at edge N appear on C with out_valid=1 after edge N.
REQ-013 When in_valid=0 at an edge, out_valid SHALL go to 0 and C SHALL hold its previous value.
REQ-014 Back-to-back in_valid SHALL be accepted every cycle, with no stall and no ready signal.
REQ-015 A == B SHALL give C = 0.
REQ-016 Boundary cases: A = 0x80000000, B = 0x7FFFFFFF gives C = 1 (signed). A = 0x7FFFFFFF, B = 0x80000000 gives C = 0.
REQ-017 Inputs are used only at sampling edges; combinational changes between edges SHALL NOT affect C.

Reset
REQ-018 While rst_n=0 at a rising edge, C SHALL become 32'd0 and out_valid SHALL become 0.
REQ-019 Reset SHALL take priority over a simultaneous in_valid; that operation is dropped.
REQ-020 The first edge after rst_n returns high SHALL sample normally.

Configuration
REQ-021 Macro LTST_32_UNSIGNED_EN defined: the is_unsigned port exists and is sampled with the operands; is_unsigned=1 gives C = (A <u B).
REQ-022 Macro LTST_32_UNSIGNED_EN undefined: the is_unsigned port is absent and the compare is always signed.

Structure
REQ-023 Package ltst_32_pkg SHALL hold:
  - the WIDTH default (32)
  - constants SLT_TRUE = 32'd1 and SLT_FALSE = 32'd0
REQ-024 Combinational sub-module ltst_32_cmp:
  - inputs: a, b, uns
  - output: lt
  - instantiated once; the top holds only the registers, reset and valid logic.

Verification
REQ-025 A=1568264235, B=10, in_valid=1 gives C=0, out_valid=1 one cycle later.
REQ-026 A=0xFFFFFFFF, B=0 gives C=1 when signed. With LTST_32_UNSIGNED_EN and is_unsigned=1, the same operands give C=0.
REQ-027 A=B=0x12345678 gives C=0. A=0x80000000, B=0x7FFFFFFF gives C=1.
REQ-028 Back-to-back inputs (3,5), (5,3), (-7,-2) on consecutive cycles give C sequence 1, 0, 1 with out_valid held at 1.
REQ-029 rst_n=0 asserted together with in_valid=1 (A=1, B=2) gives C=0 and out_valid=0 on the next cycle.
REQ-030 After a valid result, in_valid=0 gives out_valid=0 with C unchanged.
